// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Purpose  : Assembles header/cmd/len/payload/checksum frames from UART bytes.
// Revision : 1.0
// ============================================================================
module uart_frame_parser #(
    parameter logic [7:0] HEADER      = 8'h55,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 52080
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic [7:0]           I_rx_data,
    input  logic                 I_rx_done,
    output logic                 O_frame_valid,
    output logic [7:0]           O_cmd,
    output logic [3:0]           O_len,
    output logic [8*MAX_LEN-1:0] O_payload,
    output logic                 O_frame_err,
    output logic [1:0]           O_err_code
);
    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    C_MAX_LEN  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_done_d;
    logic [TW-1:0]          r_tmo;
    logic [7:0]             r_sum;
    logic [3:0]             r_idx;
    logic [3:0]             r_len_sh;
    logic [7:0]             r_cmd_sh;
    logic [8*MAX_LEN-1:0]   r_buf;
    logic                   w_byte_stb;
    logic                   w_expire;
    logic                   w_commit;
    logic                   w_err;
    logic [1:0]             w_err_code;

    assign w_byte_stb = I_rx_done & ~r_done_d;
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign w_expire   = (r_state != S_IDLE) && !w_byte_stb && (r_tmo == C_TMO_LAST);

    always_ff @(posedge I_clk) begin
        if (I_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_err_code   = 2'd0;
        if (w_expire) begin
            w_next_state = S_IDLE;
            w_err        = 1'b1;
            w_err_code   = 2'd2;
        end else if (w_byte_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (I_rx_data == HEADER) w_next_state = S_CMD;
                end
                S_CMD: w_next_state = S_LEN;
                S_LEN: begin
                    if (I_rx_data > C_MAX_LEN) begin
                        w_next_state = S_IDLE;
                        w_err        = 1'b1;
                        w_err_code   = 2'd1;
                    end else if (I_rx_data == 8'd0) begin
                        w_next_state = S_CHK;
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (r_idx == r_len_sh - 4'd1) w_next_state = S_CHK;
                end
                S_CHK: begin
                    w_next_state = S_IDLE;
                    if (I_rx_data == r_sum) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 2'd3;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_done_d      <= 1'b1;
            r_tmo         <= '0;
            r_sum         <= '0;
            r_idx         <= '0;
            r_len_sh      <= '0;
            r_cmd_sh      <= '0;
            r_buf         <= '0;
            O_frame_valid <= 1'b0;
            O_frame_err   <= 1'b0;
            O_err_code    <= '0;
            O_cmd         <= '0;
            O_len         <= '0;
            O_payload     <= '0;
        end else begin
            r_done_d      <= I_rx_done;
            O_frame_valid <= w_commit;
            O_frame_err   <= w_err;
            if (w_err) O_err_code <= w_err_code;
            if (w_commit) begin
                O_cmd     <= r_cmd_sh;
                O_len     <= r_len_sh;
                O_payload <= r_buf;
            end
            if (w_byte_stb || r_state == S_IDLE) r_tmo <= '0;
            else                                 r_tmo <= r_tmo + 1'b1;
            if (w_byte_stb) begin
                case (r_state)
                    S_IDLE: begin
                        // Clearing here leaves unused payload bytes zero at commit.
                        if (I_rx_data == HEADER) r_buf <= '0;
                    end
                    S_CMD: begin
                        r_cmd_sh <= I_rx_data;
                        r_sum    <= I_rx_data;
                    end
                    S_LEN: begin
                        r_len_sh <= I_rx_data[3:0];
                        r_sum    <= r_sum + I_rx_data;
                        r_idx    <= '0;
                    end
                    S_PAYLOAD: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_idx == 4'(i)) r_buf[8*i +: 8] <= I_rx_data;
                        end
                        r_sum <= r_sum + I_rx_data;
                        r_idx <= r_idx + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
